// File: rtl/lib_cpu_pkg.sv
// Shared opcode, funct, state and ALU code definitions for the multi-cycle CPU.
package lib_cpu;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_J     = 6'b000010,
      OP_BEQ   = 6'b000100,
      OP_BNE   = 6'b000101,
      OP_ADDI  = 6'b001000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opecode_t;

   typedef enum logic [5:0] {
      FN_ADD = 6'b100000,
      FN_SUB = 6'b100010,
      FN_AND = 6'b100100,
      FN_OR  = 6'b100101,
      FN_SLT = 6'b101010
   } funct_t;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } mc_state_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation code; valid=0 flags an unsupported funct.
module alu_decoder
   import lib_cpu::*;
(
   input  logic [5:0] funct,
   output logic [2:0] code,
   output logic       valid
);

   always_comb begin
      code  = ALU_ADD;
      valid = 1'b1;
      case (funct)
         FN_ADD:  code = ALU_ADD;
         FN_SUB:  code = ALU_SUB;
         FN_AND:  code = ALU_AND;
         FN_OR:   code = ALU_OR;
         FN_SLT:  code = ALU_SLT;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-style control FSM. Handshake: a memory access completes in
// any cycle where mem_req=1 and mem_ready=1; mem_req stays high until then.
module mc_controller
   import lib_cpu::*;
#(
   parameter int ALU_CTRL_W = 3,
   parameter int BNE_EN     = 1,
   parameter int ADDI_EN    = 1,
   parameter int J_EN       = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [5:0]            op,
   input  logic [5:0]            funct,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  iord,
   output logic                  mem_write,
   output logic                  ir_write,
   output logic                  reg_dst,
   output logic                  mem_to_reg,
   output logic                  reg_write,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            pc_src,
   output logic                  pc_en,
   output logic [ALU_CTRL_W-1:0] alu_ctrl_sig,
   output logic                  illegal,
   output logic [3:0]            state
);

   mc_state_t  state_q, state_d;
   logic [2:0] alu_code, exec_code;
   logic       funct_ok;
   logic       mem_req_r, mem_write_r, ir_write_r, reg_write_r, pc_en_r, illegal_r;

   alu_decoder u_alu_decoder (
      .funct (funct),
      .code  (exec_code),
      .valid (funct_ok)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      mem_req_r   = 1'b0;
      iord        = 1'b0;
      mem_write_r = 1'b0;
      ir_write_r  = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write_r = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_src      = 2'b00;
      pc_en_r     = 1'b0;
      illegal_r   = 1'b0;
      alu_code    = ALU_ADD;
      case (state_q)
         FETCH: begin
            mem_req_r  = 1'b1;
            alu_src_b  = 2'b01;
            ir_write_r = mem_ready;
            pc_en_r    = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_BNE:       begin state_d = (BNE_EN  != 0) ? BRANCH : FETCH; illegal_r = (BNE_EN  == 0); end
               OP_ADDI:      begin state_d = (ADDI_EN != 0) ? ADDIEX : FETCH; illegal_r = (ADDI_EN == 0); end
               OP_J:         begin state_d = (J_EN    != 0) ? JUMP   : FETCH; illegal_r = (J_EN    == 0); end
               default:      begin state_d = FETCH; illegal_r = 1'b1; end
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_req_r = 1'b1;
            iord      = 1'b1;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            mem_to_reg  = 1'b1;
            reg_write_r = 1'b1;
            state_d     = FETCH;
         end
         MEMWR: begin
            mem_req_r   = 1'b1;
            iord        = 1'b1;
            mem_write_r = mem_ready;
            if (mem_ready) state_d = FETCH;
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            alu_code  = exec_code;
            illegal_r = ~funct_ok;
            state_d   = funct_ok ? ALUWB : FETCH;
         end
         ALUWB: begin
            reg_dst     = 1'b1;
            reg_write_r = 1'b1;
            state_d     = FETCH;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_code  = ALU_SUB;
            pc_src    = 2'b01;
            pc_en_r   = (BNE_EN != 0 && op == OP_BNE) ? ~zero : zero;
            state_d   = FETCH;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = ADDIWB;
         end
         ADDIWB: begin
            reg_write_r = 1'b1;
            state_d     = FETCH;
         end
         JUMP: begin
            pc_src  = 2'b10;
            pc_en_r = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Reset is synchronous, so the state may still be stale while rst_n is low;
   // gate every side-effecting strobe directly with rst_n.
   assign mem_req      = mem_req_r   & rst_n;
   assign mem_write    = mem_write_r & rst_n;
   assign ir_write     = ir_write_r  & rst_n;
   assign reg_write    = reg_write_r & rst_n;
   assign pc_en        = pc_en_r     & rst_n;
   assign illegal      = illegal_r   & rst_n;
   assign alu_ctrl_sig = ALU_CTRL_W'(alu_code);
   assign state        = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-cycle expected output records from a spec-level
// model are queued per instruction and compared as the FSM walks its states.
module tb_mc_controller;
   import lib_cpu::*;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [1:0] alu_src_b, pc_src;
      logic       pc_en;
      logic [2:0] alu;
      logic       illegal;
   } obs_t;

   typedef struct packed {
      logic [5:0]      op, funct;
      logic            zero;
      int              len;
      logic [4:0][3:0] sts;
   } vec_t;

   logic clk, rst_n, rst2_n;
   logic [5:0] op, funct, op2, funct2;
   logic zero, mem_ready, zero2, mr2;

   logic mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, illegal;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_ctrl_sig;
   logic [3:0] state;

   logic mem_req2, iord2, mem_write2, ir_write2, reg_dst2, mem_to_reg2, reg_write2, alu_src_a2, pc_en2, illegal2;
   logic [1:0] alu_src_b2, pc_src2;
   logic [3:0] alu_ctrl_sig2;
   logic [3:0] state2;

   obs_t obs;
   logic [20:0] exp_q[$];
   int pass_cnt, total_cnt;
   vec_t vecs[15];

   mc_controller dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .alu_ctrl_sig(alu_ctrl_sig),
      .illegal(illegal), .state(state)
   );

   mc_controller #(.ALU_CTRL_W(4), .BNE_EN(0)) dut2 (
      .clk(clk), .rst_n(rst2_n), .op(op2), .funct(funct2), .zero(zero2), .mem_ready(mr2),
      .mem_req(mem_req2), .iord(iord2), .mem_write(mem_write2), .ir_write(ir_write2),
      .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2), .reg_write(reg_write2), .alu_src_a(alu_src_a2),
      .alu_src_b(alu_src_b2), .pc_src(pc_src2), .pc_en(pc_en2), .alu_ctrl_sig(alu_ctrl_sig2),
      .illegal(illegal2), .state(state2)
   );

   always_comb begin
      obs = '{st: state, mem_req: mem_req, iord: iord, mem_write: mem_write, ir_write: ir_write,
              reg_dst: reg_dst, mem_to_reg: mem_to_reg, reg_write: reg_write, alu_src_a: alu_src_a,
              alu_src_b: alu_src_b, pc_src: pc_src, pc_en: pc_en, alu: alu_ctrl_sig, illegal: illegal};
   end

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   // expected outputs of the controller (BNE_EN=1) in a given state
   function automatic logic [20:0] exp_obs(logic [3:0] st, logic [5:0] o, logic [5:0] f,
                                           logic z, logic mr);
      obs_t e;
      e = '0;
      e.st = st;
      e.alu = 3'b010;
      case (st)
         FETCH:   begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
         DECODE:  begin
            e.alu_src_b = 2'b11;
            e.illegal = !(o == 6'b100011 || o == 6'b101011 || o == 6'b000000 || o == 6'b000100 ||
                          o == 6'b000101 || o == 6'b001000 || o == 6'b000010);
         end
         MEMADR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         MEMRD:   begin e.mem_req = 1; e.iord = 1; end
         MEMWB:   begin e.mem_to_reg = 1; e.reg_write = 1; end
         MEMWR:   begin e.mem_req = 1; e.iord = 1; e.mem_write = mr; end
         EXECUTE: begin
            e.alu_src_a = 1;
            case (f)
               6'b100000: e.alu = 3'b010;
               6'b100010: e.alu = 3'b110;
               6'b100100: e.alu = 3'b000;
               6'b100101: e.alu = 3'b001;
               6'b101010: e.alu = 3'b111;
               default:   e.illegal = 1;
            endcase
         end
         ALUWB:   begin e.reg_dst = 1; e.reg_write = 1; end
         BRANCH:  begin e.alu_src_a = 1; e.alu = 3'b110; e.pc_src = 2'b01; e.pc_en = (o == 6'b000101) ? ~z : z; end
         ADDIEX:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         ADDIWB:  begin e.reg_write = 1; end
         JUMP:    begin e.pc_src = 2'b10; e.pc_en = 1; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic vec_t mk(logic [5:0] o, logic [5:0] f, logic z, int n,
                               logic [3:0] s0, logic [3:0] s1, logic [3:0] s2,
                               logic [3:0] s3, logic [3:0] s4);
      vec_t v;
      v.op = o; v.funct = f; v.zero = z; v.len = n;
      v.sts[0] = s0; v.sts[1] = s1; v.sts[2] = s2; v.sts[3] = s3; v.sts[4] = s4;
      return v;
   endfunction

   task automatic check(string name, logic [20:0] got, logic [20:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
   endtask

   // driver: apply one instruction from FETCH, queue and compare its whole trace
   task automatic run_vec(int idx);
      vec_t v;
      logic [20:0] e;
      v = vecs[idx];
      op = v.op; funct = v.funct; zero = v.zero; mem_ready = 1'b1;
      for (int k = 0; k < v.len; k++) exp_q.push_back(exp_obs(v.sts[k], v.op, v.funct, v.zero, 1'b1));
      for (int k = 0; k < v.len; k++) begin
         #1;
         e = exp_q.pop_front();
         check($sformatf("vec%0d_cyc%0d", idx, k), obs, e);
         @(negedge clk);
      end
   endtask

   function automatic logic [20:0] strobes1();
      return {15'b0, mem_req, mem_write, ir_write, reg_write, pc_en, illegal};
   endfunction

   initial begin
      int ill_cnt, bad_cnt, cyc, mw_cnt, stall_cnt;
      logic prev_dec;
      pass_cnt = 0; total_cnt = 0;
      rst_n = 0; rst2_n = 0;
      op = 0; funct = 0; zero = 0; mem_ready = 1;
      op2 = 6'b000101; funct2 = 0; zero2 = 0; mr2 = 1;

      vecs[0]  = mk(6'b100011, 6'h00, 0, 5, FETCH, DECODE, MEMADR, MEMRD, MEMWB);
      vecs[1]  = mk(6'b101011, 6'h00, 0, 4, FETCH, DECODE, MEMADR, MEMWR, FETCH);
      vecs[2]  = mk(6'b000000, 6'b100000, 0, 4, FETCH, DECODE, EXECUTE, ALUWB, FETCH);
      vecs[3]  = mk(6'b000000, 6'b100010, 0, 4, FETCH, DECODE, EXECUTE, ALUWB, FETCH);
      vecs[4]  = mk(6'b000000, 6'b100100, 1, 4, FETCH, DECODE, EXECUTE, ALUWB, FETCH);
      vecs[5]  = mk(6'b000000, 6'b100101, 0, 4, FETCH, DECODE, EXECUTE, ALUWB, FETCH);
      vecs[6]  = mk(6'b000000, 6'b101010, 0, 4, FETCH, DECODE, EXECUTE, ALUWB, FETCH);
      vecs[7]  = mk(6'b000000, 6'b111111, 0, 3, FETCH, DECODE, EXECUTE, FETCH, FETCH);
      vecs[8]  = mk(6'b000100, 6'h00, 1, 3, FETCH, DECODE, BRANCH, FETCH, FETCH);
      vecs[9]  = mk(6'b000100, 6'h00, 0, 3, FETCH, DECODE, BRANCH, FETCH, FETCH);
      vecs[10] = mk(6'b000101, 6'h00, 1, 3, FETCH, DECODE, BRANCH, FETCH, FETCH);
      vecs[11] = mk(6'b000101, 6'h00, 0, 3, FETCH, DECODE, BRANCH, FETCH, FETCH);
      vecs[12] = mk(6'b001000, 6'h00, 0, 4, FETCH, DECODE, ADDIEX, ADDIWB, FETCH);
      vecs[13] = mk(6'b000010, 6'h00, 0, 3, FETCH, DECODE, JUMP, FETCH, FETCH);
      vecs[14] = mk(6'b111111, 6'h00, 0, 2, FETCH, DECODE, FETCH, FETCH, FETCH);

      repeat (2) @(negedge clk);
      #1;
      check("reset_state", 21'(state), 21'(FETCH));
      check("reset_strobes", strobes1(), 21'd0);

      // BNE_EN=0 instance with op held at bne, while the main DUT stays in reset
      @(negedge clk);
      rst2_n = 1;
      ill_cnt = 0; bad_cnt = 0; prev_dec = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (c == 0) check("alu_zext", 21'(alu_ctrl_sig2), 21'(4'b0010));
         if (state2 == DECODE) ill_cnt += int'(illegal2);
         if (state2 != FETCH && pc_en2) bad_cnt++;
         if (state2 != FETCH && state2 != DECODE) bad_cnt++;
         if (prev_dec && state2 != FETCH) bad_cnt++;
         prev_dec = (state2 == DECODE);
         if (strobes1() != 0) bad_cnt++;
         @(negedge clk);
      end
      check("bne_dis_illegal", 21'(ill_cnt), 21'd5);
      check("bne_dis_no_branch", 21'(bad_cnt), 21'd0);

      rst_n = 1;
      #1;
      check("first_fetch_req", obs, exp_obs(FETCH, op, funct, zero, 1'b1));
      @(negedge clk);
      check("first_fetch_adv", 21'(state), 21'(DECODE));
      @(negedge clk);
      @(negedge clk);   // DECODE of op 0/funct 0 -> EXECUTE, illegal funct -> FETCH

      for (int i = 0; i < 15; i++) run_vec(i);

      // sw with three stalled MEMWR cycles
      op = 6'b101011; funct = 0; zero = 0;
      cyc = 0; mw_cnt = 0; stall_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (state == MEMWR && stall_cnt < 3) begin mem_ready = 0; stall_cnt++; end
         else mem_ready = 1;
         #1;
         cyc++;
         mw_cnt += int'(mem_write);
         @(negedge clk);
         if (state == FETCH) break;
      end
      check("sw_stall_cycles", 21'(cyc), 21'd7);
      check("sw_stall_write_once", 21'(mw_cnt), 21'd1);

      // reset in the middle of a MEMRD stall
      op = 6'b100011; mem_ready = 1;
      @(negedge clk);
      @(negedge clk);
      mem_ready = 0;
      @(negedge clk);
      #1;
      check("memrd_stall", obs, exp_obs(MEMRD, op, funct, zero, 1'b0));
      @(negedge clk);
      #1;
      check("memrd_hold", 21'(state), 21'(MEMRD));
      rst_n = 0;
      #1;
      check("rst_gate_strobes", strobes1(), 21'd0);
      @(negedge clk);
      #1;
      check("rst_midstall_state", 21'(state), 21'(FETCH));
      check("rst_midstall_strobes", strobes1(), 21'd0);
      rst_n = 1; mem_ready = 1;
      #1;
      check("post_rst_fetch", obs, exp_obs(FETCH, op, funct, zero, 1'b1));
      @(negedge clk);
      #1;
      check("post_rst_decode", 21'(state), 21'(DECODE));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
